// File: rtl/game_countdown_pkg.sv
// Shared definitions for the game status FSM and the countdown sequencer.
package game_countdown_pkg;

  typedef enum logic [2:0] {
    STAT_NORMAL       = 3'b000,
    STAT_MENU         = 3'b001,
    STAT_SETUP        = 3'b010,
    STAT_SCORE        = 3'b011,
    STAT_GAME_INITIAL = 3'b100,
    STAT_GAME_CNTDOWN = 3'b101,
    STAT_GAME_ING     = 3'b110,
    STAT_GAME_OVER    = 3'b111
  } stat_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_WAIT_CNT = 3'd2,
    ST_COUNT    = 3'd3,
    ST_GO       = 3'd4,
    ST_HOLD     = 3'd5
  } cd_state_e;

  localparam logic [3:0] CNT_BLANK = 4'hF;

  function automatic logic stat_in_cnt_set(stat_e s);
    return (s == STAT_GAME_INITIAL) || (s == STAT_GAME_CNTDOWN);
  endfunction

endpackage

// File: rtl/game_countdown_tick_sync.sv
// Two-flop synchroniser plus rising-edge detector; tick is one clk cycle wide.
module game_countdown_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign tick = s2_q & ~prev_q;

endmodule

// File: rtl/game_countdown.sv
// Countdown sequencer between the game status FSM and the playfield/display.
// state    | meaning
// IDLE     | waiting for GAME_INITIAL
// CLEAR    | clr_req high, waiting for clr_ack or timeout
// WAIT_CNT | board cleared, waiting for GAME_CNTDOWN
// COUNT    | digit decrements once per game_clk tick
// GO       | "GO" shown for GO_TICKS ticks
// HOLD     | countdown finished, parked until the game leaves play
module game_countdown
  import game_countdown_pkg::*;
#(
  parameter int COUNT_START = 3,
  parameter int GO_TICKS    = 1,
  parameter int CLR_TIMEOUT = 1023
) (
  input  logic       global_clk,
  input  logic       rst_n,
  input  logic [2:0] stat_in,
  input  logic       game_clk,
  input  logic       clr_ack,
  output logic       clr_req,
  output logic       init_done,
  output logic       cnt_done,
  output logic [3:0] cnt_digit,
  output logic       cnt_go,
  output logic       cnt_active
);

  localparam int TO_W = $clog2(CLR_TIMEOUT + 1);
  localparam int GO_W = $clog2(GO_TICKS + 1);
  localparam logic [TO_W-1:0] TO_MAX      = TO_W'(CLR_TIMEOUT);
  localparam logic [GO_W-1:0] GO_LAST     = GO_W'(GO_TICKS - 1);
  localparam logic [3:0]      DIGIT_START = 4'(COUNT_START);

  cd_state_e       state_q, state_d;
  logic            clr_req_q, clr_req_d;
  logic            init_done_q, init_done_d;
  logic            cnt_done_q, cnt_done_d;
  logic [3:0]      digit_q, digit_d;
  logic            go_q, go_d;
  logic            active_q, active_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [GO_W-1:0] go_cnt_q, go_cnt_d;
  logic            tick;
  logic            abort;
  stat_e           stat;

  assign stat = stat_e'(stat_in);

  game_countdown_tick_sync u_tick_sync (
    .clk      (global_clk),
    .rst_n    (rst_n),
    .async_in (game_clk),
    .tick     (tick)
  );

  always_comb begin
    abort = 1'b0;
    case (state_q)
      ST_CLEAR:                     abort = (stat != STAT_GAME_INITIAL);
      ST_WAIT_CNT, ST_COUNT, ST_GO: abort = !stat_in_cnt_set(stat);
      default:                      abort = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    clr_req_d   = clr_req_q;
    init_done_d = 1'b0;
    cnt_done_d  = 1'b0;
    digit_d     = digit_q;
    go_d        = go_q;
    to_d        = to_q;
    go_cnt_d    = go_cnt_q;

    // Abort outranks any tick or clr_ack seen in the same cycle.
    if (abort) begin
      state_d   = ST_IDLE;
      clr_req_d = 1'b0;
      digit_d   = CNT_BLANK;
      go_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stat == STAT_GAME_INITIAL) begin
            state_d   = ST_CLEAR;
            clr_req_d = 1'b1;
            to_d      = '0;
          end
        end
        ST_CLEAR: begin
          if (clr_ack || (to_q == TO_MAX)) begin
            state_d     = ST_WAIT_CNT;
            clr_req_d   = 1'b0;
            init_done_d = 1'b1;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        ST_WAIT_CNT: begin
          if (stat == STAT_GAME_CNTDOWN) begin
            go_cnt_d = '0;
            if (COUNT_START == 0) begin
              state_d = ST_GO;
              digit_d = 4'd0;
              go_d    = 1'b1;
            end else begin
              state_d = ST_COUNT;
              digit_d = DIGIT_START;
            end
          end
        end
        ST_COUNT: begin
          if (tick) begin
            if (digit_q <= 4'd1) begin
              state_d = ST_GO;
              digit_d = 4'd0;
              go_d    = 1'b1;
            end else begin
              digit_d = digit_q - 4'd1;
            end
          end
        end
        ST_GO: begin
          if (tick) begin
            if (go_cnt_q == GO_LAST) begin
              state_d    = ST_HOLD;
              go_d       = 1'b0;
              digit_d    = CNT_BLANK;
              cnt_done_d = 1'b1;
            end else begin
              go_cnt_d = go_cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if ((stat != STAT_GAME_CNTDOWN) && (stat != STAT_GAME_ING)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_req_q   <= 1'b0;
      init_done_q <= 1'b0;
      cnt_done_q  <= 1'b0;
      digit_q     <= CNT_BLANK;
      go_q        <= 1'b0;
      active_q    <= 1'b0;
      to_q        <= '0;
      go_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_req_q   <= clr_req_d;
      init_done_q <= init_done_d;
      cnt_done_q  <= cnt_done_d;
      digit_q     <= digit_d;
      go_q        <= go_d;
      active_q    <= active_d;
      to_q        <= to_d;
      go_cnt_q    <= go_cnt_d;
    end
  end

  assign clr_req    = clr_req_q;
  assign init_done  = init_done_q;
  assign cnt_done   = cnt_done_q;
  assign cnt_digit  = digit_q;
  assign cnt_go     = go_q;
  assign cnt_active = active_q;

endmodule

// File: tb/tb_game_countdown.sv
// Scoreboard bench: stimulus queues the output events the sequence should produce,
// a monitor pops and compares every output change or pulse it observes.
module tb_game_countdown;
  import game_countdown_pkg::*;

  localparam int COUNT_START = 3;
  localparam int GO_TICKS    = 1;
  localparam int CLR_TIMEOUT = 15;

  logic       global_clk = 1'b0;
  logic       rst_n      = 1'b1;
  logic [2:0] stat_in    = 3'b000;
  logic       game_clk   = 1'b0;
  logic       clr_ack    = 1'b0;
  logic       clr_req, init_done, cnt_done, cnt_go, cnt_active;
  logic [3:0] cnt_digit;

  game_countdown #(
    .COUNT_START (COUNT_START),
    .GO_TICKS    (GO_TICKS),
    .CLR_TIMEOUT (CLR_TIMEOUT)
  ) dut (
    .global_clk (global_clk),
    .rst_n      (rst_n),
    .stat_in    (stat_in),
    .game_clk   (game_clk),
    .clr_ack    (clr_ack),
    .clr_req    (clr_req),
    .init_done  (init_done),
    .cnt_done   (cnt_done),
    .cnt_digit  (cnt_digit),
    .cnt_go     (cnt_go),
    .cnt_active (cnt_active)
  );

  always #5 global_clk = ~global_clk;

  typedef enum int {EV_REQ, EV_INIT, EV_ACT, EV_DIG, EV_GO, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  function automatic void push(ev_kind_e k, int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic observe(input ev_kind_e k, input int v);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected none (t=%0t)",
               int'(k), v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        fails++;
        $display("FAIL event: got kind %0d value %0d, expected kind %0d value %0d (t=%0t)",
                 int'(k), v, int'(e.kind), e.val, $time);
      end
    end
  endtask

  // Monitor: one event per output change or pulse, in a fixed per-cycle order.
  initial begin
    logic       p_req, p_act, p_go;
    logic [3:0] p_dig;
    p_req = 1'b0; p_act = 1'b0; p_go = 1'b0; p_dig = CNT_BLANK;
    forever begin
      @(negedge global_clk);
      if (!rst_n) begin
        p_req = 1'b0; p_act = 1'b0; p_go = 1'b0; p_dig = CNT_BLANK;
      end else begin
        if (clr_req != p_req)    observe(EV_REQ, int'(clr_req));
        if (init_done)           observe(EV_INIT, 1);
        if (cnt_active != p_act) observe(EV_ACT, int'(cnt_active));
        if (cnt_digit != p_dig)  observe(EV_DIG, int'(cnt_digit));
        if (cnt_go != p_go)      observe(EV_GO, int'(cnt_go));
        if (cnt_done)            observe(EV_DONE, 1);
        check("pulse_exclusive", int'(init_done & cnt_done), 0);
        p_req = clr_req; p_act = cnt_active; p_go = cnt_go; p_dig = cnt_digit;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge global_clk);
  endtask

  task automatic pulse();
    game_clk = 1'b1;
    cyc(3);
    game_clk = 1'b0;
    cyc($urandom_range(2, 4));
  endtask

  function automatic logic [2:0] pick_code(logic [2:0] xa, logic [2:0] xb, logic [2:0] xc);
    logic [2:0] c;
    do c = 3'($urandom_range(0, 7)); while (c == xa || c == xb || c == xc);
    return c;
  endfunction

  // mode 0: ack d cycles after clr_req, 1: ack already high, 2: timeout, 3: abort
  task automatic do_clear(input int mode, input int d, output bit ok);
    ok = 1'b1;
    if (mode == 1) clr_ack = 1'b1;
    stat_in = 3'b100;
    push(EV_REQ, 1); push(EV_ACT, 1);
    case (mode)
      0: begin
        cyc(1 + d);
        check("init_before_ack", int'(init_done), 0);
        clr_ack = 1'b1;
        push(EV_REQ, 0); push(EV_INIT, 1);
        cyc(1);
        check("init_after_ack", int'(init_done), 1);
        check("req_after_ack", int'(clr_req), 0);
      end
      1: begin
        push(EV_REQ, 0); push(EV_INIT, 1);
        cyc(2);
        check("init_ack_on_entry", int'(init_done), 1);
      end
      2: begin
        push(EV_REQ, 0); push(EV_INIT, 1);
        cyc(CLR_TIMEOUT + 1);
        check("init_before_timeout", int'(init_done), 0);
        cyc(1);
        check("init_at_timeout", int'(init_done), 1);
      end
      default: begin
        cyc(1 + d);
        stat_in = pick_code(3'b100, 3'b100, 3'b100);
        if ($urandom_range(0, 1) == 1) clr_ack = 1'b1;
        push(EV_REQ, 0); push(EV_ACT, 0);
        cyc(2);
        check("clear_abort_active", int'(cnt_active), 0);
        ok = 1'b0;
      end
    endcase
    cyc(1);
    clr_ack = 1'b0;
  endtask

  // Reference: digit counts COUNT_START..0, then GO lasts GO_TICKS ticks.
  task automatic do_count(input int pre, input bit abort_wait, input int abort_at,
                          input bit with_tick, input bit hold_ing);
    int  digit, go_n;
    bit  in_go, done;
    for (int i = 0; i < pre; i++) pulse();
    if (abort_wait) begin
      stat_in = pick_code(3'b100, 3'b101, 3'b101);
      push(EV_ACT, 0);
      cyc(3);
      check("wait_abort_active", int'(cnt_active), 0);
      return;
    end
    stat_in = 3'b101;
    push(EV_DIG, COUNT_START);
    cyc(2);
    check("count_start_digit", int'(cnt_digit), COUNT_START);
    digit = COUNT_START; go_n = 0; in_go = 1'b0; done = 1'b0;
    for (int t = 0; !done; t++) begin
      if (t == abort_at) begin
        if (with_tick) begin
          game_clk = 1'b1;
          cyc(2);
        end
        stat_in = pick_code(3'b100, 3'b101, 3'b101);
        push(EV_ACT, 0); push(EV_DIG, 15);
        if (in_go) push(EV_GO, 0);
        cyc(1);
        game_clk = 1'b0;
        cyc(3);
        check("abort_digit", int'(cnt_digit), 15);
        check("abort_go", int'(cnt_go), 0);
        return;
      end
      if (!in_go) begin
        digit = digit - 1;
        push(EV_DIG, digit);
        if (digit == 0) begin
          push(EV_GO, 1);
          in_go = 1'b1;
        end
      end else begin
        go_n = go_n + 1;
        if (go_n == GO_TICKS) begin
          push(EV_DIG, 15); push(EV_GO, 0); push(EV_DONE, 1);
          done = 1'b1;
        end
      end
      pulse();
    end
    check("hold_digit", int'(cnt_digit), 15);
    check("hold_active", int'(cnt_active), 1);
    if (hold_ing) begin
      stat_in = 3'b110;
      cyc($urandom_range(1, 4));
      pulse();
    end
    stat_in = pick_code(3'b100, 3'b101, 3'b110);
    push(EV_ACT, 0);
    cyc(3);
  endtask

  initial begin
    bit ok;
    #1 rst_n = 1'b0;
    cyc(3);
    check("rst_clr_req", int'(clr_req), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_cnt_done", int'(cnt_done), 0);
    check("rst_digit", int'(cnt_digit), 15);
    check("rst_go", int'(cnt_go), 0);
    check("rst_active", int'(cnt_active), 0);
    rst_n = 1'b1;
    cyc(2);

    // ack 5 cycles after request, then a full countdown with HOLD in GAME_ING
    do_clear(0, 5, ok);
    do_count(0, 1'b0, 99, 1'b0, 1'b1);

    // timeout path; ticks in WAIT_CNT ignored; abort at digit 2 with a coincident tick
    do_clear(2, 0, ok);
    do_count(2, 1'b0, 1, 1'b1, 1'b0);

    // ack high on entry, then asynchronous reset mid-count at digit 2
    do_clear(1, 0, ok);
    stat_in = 3'b101;
    push(EV_DIG, 3);
    cyc(2);
    push(EV_DIG, 2);
    pulse();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_clr_req", int'(clr_req), 0);
    check("midrst_init_done", int'(init_done), 0);
    check("midrst_cnt_done", int'(cnt_done), 0);
    check("midrst_digit", int'(cnt_digit), 15);
    check("midrst_go", int'(cnt_go), 0);
    check("midrst_active", int'(cnt_active), 0);
    stat_in = 3'b000;
    cyc(2);
    #2 rst_n = 1'b1;
    cyc(5);
    check("post_rst_active", int'(cnt_active), 0);
    check("post_rst_digit", int'(cnt_digit), 15);

    for (int g = 0; g < 30; g++) begin
      do_clear($urandom_range(0, 3), $urandom_range(1, 8), ok);
      if (ok) begin
        do_count($urandom_range(0, 2), ($urandom_range(0, 5) == 0),
                 $urandom_range(0, COUNT_START + GO_TICKS + 2),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      cyc($urandom_range(1, 3));
    end

    cyc(5);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_countdown.md
Name: game_countdown

Overview:
- Sequencer directly downstream of the game status FSM. It consumes the 3-bit status code and drives the GAME_INITIAL -> GAME_CNTDOWN -> GAME_ING progression.
- Runs a board-clear handshake with the playfield block, then counts seconds down from the game_clk tick for the 7-segment display.
- Returns single-cycle pulses to the status FSM so it can advance.

Parameters:
- COUNT_START, 3, first digit shown in the countdown (1..9).
- GO_TICKS, 1, number of game_clk ticks the "GO" indication is held after the digit reaches 0.
- CLR_TIMEOUT, 1023, global_clk cycles to wait for clr_ack before forcing progress.

Ports:
- global_clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stat_in  in  3  current status code from the status FSM.
- game_clk  in  1  slow square wave (about 1 Hz), asynchronous to global_clk.
- clr_ack  in  1  playfield reports the board and score are cleared (level).
- clr_req  out  1  request to the playfield to clear the board and score (level).
- init_done  out  1  one-cycle pulse: initialisation complete.
- cnt_done  out  1  one-cycle pulse: countdown finished, game may start.
- cnt_digit  out  4  BCD digit for display; 0xF means blank.
- cnt_go  out  1  high while "GO" is displayed.
- cnt_active  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, clr_req=0, init_done=0, cnt_done=0, cnt_digit=0xF, cnt_go=0, cnt_active=0, tick counters and timeout counter cleared, synchroniser flops cleared.
- game_clk handling:
  - Pass through a 2-flop synchroniser, then a third flop for edge detection.
  - tick = sync & ~prev. It is high for one global_clk cycle per rising edge.
  - Tick latency from the game_clk edge is 2-3 cycles.
- States (3-bit encoding): IDLE, CLEAR, WAIT_CNT, COUNT, GO, HOLD.
- IDLE:
  - stat_in==GAME_INITIAL -> CLEAR.
  - Set clr_req=1 and reset the timeout counter.
- CLEAR:
  - clr_req stays high.
  - On clr_ack=1, or timeout counter == CLR_TIMEOUT: clr_req=0, pulse init_done for exactly one cycle, go to WAIT_CNT.
  - clr_ack already high on entry: exit on the first CLEAR cycle.
- WAIT_CNT:
  - stat_in==GAME_CNTDOWN -> COUNT, with cnt_digit=COUNT_START.
  - Ticks arriving in WAIT_CNT are ignored.
- COUNT:
  - Each tick decrements cnt_digit.
  - A tick while cnt_digit==1 sets cnt_digit=0 and cnt_go=1, then goes to GO.
  - With COUNT_START==0 the block goes straight to GO on entry.
  - cnt_digit never wraps below 0.
- GO:
  - Count GO_TICKS ticks.
  - On the last one: cnt_go=0, cnt_digit=0xF, pulse cnt_done for one cycle, go to HOLD.
- HOLD:
  - Stay while stat_in is GAME_CNTDOWN or GAME_ING.
  - Any other code -> IDLE.
- Abort rule (all states except IDLE and HOLD):
  - If stat_in leaves the expected set, go to IDLE the next cycle: clr_req=0, cnt_digit=0xF, cnt_go=0, no pulses.
  - Expected set: GAME_INITIAL in CLEAR; GAME_INITIAL or GAME_CNTDOWN in WAIT_CNT, COUNT and GO.
  - Abort has priority over a simultaneous tick or clr_ack.
- init_done and cnt_done are never high in the same cycle and never held longer than one cycle.
- cnt_active=1 in every state except IDLE.
- Width rules:
  - Timeout counter is $clog2(CLR_TIMEOUT+1) bits and saturates.
  - GO tick counter is $clog2(GO_TICKS+1) bits.

Decomposition:
- Shared package/header holds:
  - the eight STAT_* 3-bit codes (NORMAL 000 … GAME_OVER 111), moved out of the status FSM so both blocks share one definition;
  - the countdown state encodings;
  - the CNT_BLANK=4'hF constant.
- One sub-module, tick_sync: a 2-flop synchroniser plus rising-edge detector, async active-low reset, output tick. It is reusable for the pushbutton path.

Test Plan:
- Reset mid-COUNT at digit 2 (drop rst_n asynchronously) -> all outputs at reset values immediately; IDLE after release; no pulse.
- stat_in=100, clr_ack rises 5 cycles after clr_req -> clr_req falls and init_done pulses once 1 cycle after clr_ack is seen; state WAIT_CNT.
- stat_in=100, clr_ack never asserted, CLR_TIMEOUT=15 -> init_done pulses once exactly 16 cycles after CLEAR entry.
- stat_in=101, COUNT_START=3, GO_TICKS=1, 4 game_clk edges -> cnt_digit sequence 3,2,1,0; cnt_go high 0→4th tick; cnt_done pulses once at the 4th tick; cnt_digit=0xF.
- stat_in forced to 000 while cnt_digit=2 and a tick in the same cycle -> IDLE next cycle, cnt_digit=0xF, cnt_go=0, no cnt_done.
- game_clk toggled while in WAIT_CNT, then stat_in=101 -> countdown starts at COUNT_START (earlier ticks ignored); game_clk glitch-free edges spaced 3 cycles each give exactly one decrement per edge.
